name_hash_stream: RTL and testbench
===================================

Name: name_hash_stream

Overview:
- Streaming, parametrised successor to the single-cycle 64-bit→10-bit name hash.
- Absorbs a variable-length NDN name as a sequence of DATA_W-bit words over a valid/ready handshake and folds them into a HASH_W-bit index for the PIT/FIB/CS tables.
- Delivers the result, word count and an over-length error flag through a one-deep registered output with its own valid/ready handshake.

Parameters:
- DATA_W, 64, input word width in bits (≥ HASH_W).
- HASH_W, 10, output hash width in bits.
- MAX_WORDS, 8, maximum legal words per name; beyond this, err is flagged.
- ROT, 5, left-rotate amount applied to the accumulator per word (0 < ROT < DATA_W).
- SEED, 0, DATA_W-bit accumulator initial value at the start of each name.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  name word.
- in_last  in  1  final word of the current name.
- hash_valid  out  1  result register holds an unconsumed result.
- hash_ready  in  1  downstream consumes the result.
- hash  out  HASH_W  folded hash.
- hash_len  out  $clog2(MAX_WORDS+1)  words in the name, saturating at MAX_WORDS.
- hash_err  out  1  name exceeded MAX_WORDS words.

Behaviour:
- Reset (rst=0, async): acc=SEED, word count=0, overflow=0, hash_valid=0, hash=0, hash_len=0, hash_err=0. in_ready=0 while rst=0 and 1 from the first edge after release.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when hash_valid && hash_ready.
- in_ready = !hash_valid || hash_ready. This is combinational; a full output register that is being drained accepts a word in the same cycle.
- Per accepted word: acc_next = rotl(acc, ROT) ^ in_data (DATA_W wide). Word count increments, saturating at MAX_WORDS. Overflow sets if the count is already MAX_WORDS.
- On an accepted word with in_last=1:
  - fold = XOR of consecutive HASH_W slices of acc_next, LSB first; the top partial slice is zero-extended.
  - Next cycle: hash=fold, hash_len=saturated count including this word, hash_err=overflow including this word, hash_valid=1.
  - acc, count and overflow reset to SEED/0/0 for the next name.
  - Latency: last word accepted in cycle N → hash_valid in cycle N+1.
- Single-word name (first word has in_last=1) is legal; result is fold(rotl(SEED,ROT)^data).
- Back-to-back names with no idle cycles are supported.
- hash, hash_len and hash_err are stable while hash_valid=1 and hash_ready=0.
- hash_valid clears on an output transfer, unless a new last word is accepted in the same cycle. In that case the new result loads and hash_valid stays 1.
- Non-last words are accepted while hash_valid=1 only if in_ready=1; accumulation of the next name proceeds independently of the held result.
- in_valid=0 mid-name: state holds indefinitely.
- in_data/in_last are ignored when no input transfer occurs.
- Reset asserted mid-name or with a pending result discards everything; no partial result is emitted.
- hash_err results are still delivered, with hash computed over all words; the consumer decides whether to drop the name.

Test Plan:
- Defaults, single word 1 with in_last → one cycle later hash=0x001, hash_len=1, hash_err=0, hash_valid=1.
- Two words 1 then 2 (last) → acc=0x22, hash=0x022, hash_len=2.
- Single word 0xFFFF_FFFF_FFFF_FFFF → six 0x3FF slices cancel, top nibble gives hash=0x00F.
- Backpressure:
  - hold hash_ready=0 after a result → in_ready=0, outputs stable for 5 cycles.
  - raise hash_ready with a new last word presented → same-cycle accept, next result loads, hash_valid never drops.
- Overflow: 9 words of 0 then last (10 total) → hash_len=8, hash_err=1, hash=0x000; the following single-word name 1 gives hash_err=0, hash=0x001.
- Sweep and reset:
  - data=ii for ii=0..999 as single-word names; compare each hash against a reference model.
  - assert rst low after the 2nd word of a 3-word name → hash_valid=0 immediately; the next name hashes from SEED.

Source files
------------

// File: rtl/name_hash_stream.sv
// Streaming NDN name hash: rotate-XOR accumulates DATA_W-bit words and folds the
// accumulator into a HASH_W-bit table index held in a one-deep output register.
module name_hash_stream #(
  parameter int                DATA_W    = 64,
  parameter int                HASH_W    = 10,
  parameter int                MAX_WORDS = 8,
  parameter int                ROT       = 5,
  parameter logic [DATA_W-1:0] SEED      = '0,
  localparam int               LEN_W     = $clog2(MAX_WORDS+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [HASH_W-1:0] hash,
  output logic [LEN_W-1:0]  hash_len,
  output logic              hash_err
);

  localparam int NSL = (DATA_W + HASH_W - 1) / HASH_W;

  // Top partial slice is zero-extended by padding to a whole number of slices.
  function automatic logic [HASH_W-1:0] fold(input logic [DATA_W-1:0] v);
    logic [NSL*HASH_W-1:0] ext;
    logic [HASH_W-1:0]     f;
    ext = '0;
    ext[DATA_W-1:0] = v;
    f = '0;
    for (int i = 0; i < NSL; i++) f ^= ext[i*HASH_W +: HASH_W];
    return f;
  endfunction

  logic [DATA_W-1:0] acc_q, acc_d, acc_nx;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_nx;
  logic              ovf_q, ovf_d, ovf_nx;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              hv_q, hv_d;
  logic              rdy_en_q;
  logic              at_max, in_xfer, out_xfer;

  // rdy_en_q keeps in_ready low throughout reset even though the output is empty.
  assign in_ready = rdy_en_q & (~hv_q | hash_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = hv_q & hash_ready;

  assign at_max = (cnt_q == LEN_W'(MAX_WORDS));
  assign acc_nx = {acc_q[DATA_W-1-ROT:0], acc_q[DATA_W-1:DATA_W-ROT]} ^ in_data;
  assign cnt_nx = at_max ? cnt_q : cnt_q + LEN_W'(1);
  assign ovf_nx = ovf_q | at_max;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    hash_d = hash_q;
    len_d  = len_q;
    err_d  = err_q;
    hv_d   = hv_q;
    if (out_xfer) hv_d = 1'b0;
    if (in_xfer) begin
      if (in_last) begin
        acc_d  = SEED;
        cnt_d  = '0;
        ovf_d  = 1'b0;
        hash_d = fold(acc_nx);
        len_d  = cnt_nx;
        err_d  = ovf_nx;
        hv_d   = 1'b1;
      end else begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        ovf_d = ovf_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= SEED;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      hash_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      hv_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      hash_q   <= hash_d;
      len_q    <= len_d;
      err_q    <= err_d;
      hv_q     <= hv_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign hash_valid = hv_q;
  assign hash       = hash_q;
  assign hash_len   = len_q;
  assign hash_err   = err_q;

endmodule

// File: tb/tb_name_hash_stream.sv
// Directed + randomized bench for name_hash_stream against a word-list reference model.
module tb_name_hash_stream;

  localparam int DATA_W = 64, HASH_W = 10, MAX_WORDS = 8, ROT = 5;
  localparam logic [63:0] SEED = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [63:0] in_data = '0;
  logic        hash_valid, hash_ready = 1'b1, hash_err;
  logic [9:0]  hash;
  logic [3:0]  hash_len;

  int checks = 0, failures = 0;
  logic [63:0] name_q[$];
  logic [9:0]  held;

  name_hash_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .hash_valid(hash_valid),
    .hash_ready(hash_ready), .hash(hash), .hash_len(hash_len), .hash_err(hash_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: rotate by ROT via a doubled word, fold by bit position mod HASH_W.
  function automatic logic [9:0] ref_hash();
    logic [63:0]  acc;
    logic [127:0] dd;
    logic [9:0]   h;
    acc = SEED;
    foreach (name_q[k]) begin
      dd  = {acc, acc};
      acc = dd[127-ROT -: 64] ^ name_q[k];
    end
    h = '0;
    for (int b = 0; b < DATA_W; b++) h[b % HASH_W] ^= acc[b];
    return h;
  endfunction

  // Present one word, wait (bounded) for in_ready, then let it transfer.
  task automatic put(input logic [63:0] d, input logic last);
    int n;
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    name_q.push_back(d);
    tick();
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 64'(hash_valid), 64'd1);
    chk({tag, "_hash"},  64'(hash), 64'(ref_hash()));
    chk({tag, "_len"},   64'(hash_len), (name_q.size() > MAX_WORDS) ? 64'(MAX_WORDS) : 64'(name_q.size()));
    chk({tag, "_err"},   64'(hash_err), 64'(name_q.size() > MAX_WORDS));
    name_q.delete();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(hash_valid), 64'd0);
    chk("rst_hash", 64'(hash), 64'd0);
    chk("rst_len", 64'(hash_len), 64'd0);
    chk("rst_err", 64'(hash_err), 64'd0);
    tick(); tick();
    chk("rst_held_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single word 1
    put(64'd1, 1'b1);
    in_valid = 1'b0;
    chk("w1_hash_const", 64'(hash), 64'h001);
    check_result("w1");
    tick();
    chk("w1_drained", 64'(hash_valid), 64'd0);

    // Two words 1, 2 -> 0x22
    put(64'd1, 1'b0);
    in_valid = 1'b0; in_data = 64'hDEAD_BEEF; in_last = 1'b1;
    tick(); tick();
    put(64'd2, 1'b1);
    in_valid = 1'b0;
    chk("w12_hash_const", 64'(hash), 64'h022);
    check_result("w12");

    // All-ones single word -> 0x00F
    put('1, 1'b1);
    in_valid = 1'b0;
    chk("ones_hash_const", 64'(hash), 64'h00F);
    check_result("ones");
    tick();

    // Backpressure: hold result for 5 cycles
    hash_ready = 1'b0;
    put(64'h1234_5678_9ABC_DEF0, 1'b1);
    held = hash;
    check_result("bp");
    in_valid = 1'b1; in_data = 64'h77; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stable", 64'(hash), 64'(held));
      chk("bp_valid", 64'(hash_valid), 64'd1);
      tick();
    end
    hash_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    name_q.push_back(64'h77);
    tick();
    in_valid = 1'b0;
    check_result("bp_swap");
    tick();
    chk("bp_drained", 64'(hash_valid), 64'd0);

    // Overflow: 10 zero words
    for (int k = 0; k < 9; k++) put(64'd0, 1'b0);
    put(64'd0, 1'b1);
    in_valid = 1'b0;
    chk("ovf_len_const", 64'(hash_len), 64'd8);
    chk("ovf_err_const", 64'(hash_err), 64'd1);
    check_result("ovf");
    put(64'd1, 1'b1);
    in_valid = 1'b0;
    chk("after_ovf_err", 64'(hash_err), 64'd0);
    check_result("after_ovf");

    // Back-to-back single-word sweep
    for (int ii = 0; ii < 1000; ii++) begin
      put(64'(ii), 1'b1);
      check_result("sweep");
    end
    in_valid = 1'b0;
    tick();

    // Randomized names: random lengths, data, idle gaps and consumer stalls
    for (int nm = 0; nm < 60; nm++) begin
      int len;
      len = $urandom_range(1, 11);
      for (int k = 0; k < len; k++) begin
        put({$urandom, $urandom}, k == len - 1);
        in_valid = 1'b0; in_data = {$urandom, $urandom}; in_last = 1'($urandom);
        if (k != len - 1) repeat ($urandom_range(0, 2)) tick();
      end
      check_result("rand");
      if ($urandom_range(0, 1) == 1) begin
        hash_ready = 1'b0;
        held = hash;
        repeat ($urandom_range(1, 3)) tick();
        chk("rand_hold", 64'(hash), 64'(held));
        hash_ready = 1'b1;
      end
      tick();
      chk("rand_drained", 64'(hash_valid), 64'd0);
    end

    // Reset with a pending result
    hash_ready = 1'b0;
    put(64'd5, 1'b1);
    in_valid = 1'b0;
    name_q.delete();
    chk("pend_valid", 64'(hash_valid), 64'd1);
    rst = 1'b0; #1;
    chk("pend_rst_valid", 64'(hash_valid), 64'd0);
    chk("pend_rst_in_ready", 64'(in_ready), 64'd0);
    hash_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-name after 2 of 3 words
    put(64'hAAAA, 1'b0);
    put(64'hBBBB, 1'b0);
    in_valid = 1'b0;
    name_q.delete();
    rst = 1'b0; #1;
    chk("mid_rst_valid", 64'(hash_valid), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_no_result", 64'(hash_valid), 64'd0);
    put(64'd1, 1'b1);
    in_valid = 1'b0;
    chk("mid_rst_seed_hash", 64'(hash), 64'h001);
    check_result("mid_rst_next");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
